// File: rtl/zeroriscy_irq_ctrl_pkg.sv
// zeroriscy_defines: shared definitions for the zero-riscy interrupt controller.
//   IRQ_ID_W       width of an interrupt ID (up to 32 lines)
//   IRQ_CAUSE_FLAG interrupt flag bit prepended to the ID in the exception cause
//   irq_state_t    request/service handshake states
package zeroriscy_defines;

  localparam int unsigned IRQ_ID_W       = 5;
  localparam logic        IRQ_CAUSE_FLAG = 1'b1;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_SERVICE
  } irq_state_t;

endpackage

// File: rtl/zeroriscy_irq_ctrl_arbiter.sv
// zeroriscy_irq_arbiter: combinational priority arbiter.
//   elig  : per-line eligibility
//   prio  : per-line priority, line k at [k*PRIO_W +: PRIO_W]
//   valid : at least one line eligible
//   id    : winner; highest priority, lowest ID on a tie
module zeroriscy_irq_arbiter
  import zeroriscy_defines::*;
#(
  parameter int unsigned N_IRQ  = 32,
  parameter int unsigned PRIO_W = 2
) (
  input  logic [N_IRQ-1:0]        elig,
  input  logic [N_IRQ*PRIO_W-1:0] prio,
  output logic                    valid,
  output logic [IRQ_ID_W-1:0]     id
);

  logic [PRIO_W-1:0] best;

  // Ascending scan with a strict '>' keeps the lowest ID among equal priorities.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    best  = '0;
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      if (elig[k] && (!valid || (prio[k*PRIO_W +: PRIO_W] > best))) begin
        valid = 1'b1;
        id    = IRQ_ID_W'(k);
        best  = prio[k*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

// File: rtl/zeroriscy_irq_ctrl.sv
// zeroriscy_irq_ctrl: interrupt controller for the zero-riscy core.
// Arbitrates up to N_IRQ prioritised, maskable lines, offers one frozen ID to
// the core through a req/ack handshake and tracks it until end-of-interrupt.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   irq_i             interrupt lines
//   irq_mask_i        per-line enable
//   irq_prio_i        per-line priority (PRIO_W bits each)
//   irq_thresh_i      line eligible only if priority > threshold
//   irq_glb_en_i      global enable (MSTATUS.MIE)
//   irq_edge_i        per-line edge mode (only with ZERORISCY_IRQ_EDGE_EN)
//   irq_req_o/ack_i   request handshake
//   irq_eoi_i         end of interrupt (mret)
//   irq_id_o          ID of requested / in-service line
//   exc_cause_o       {1, id}
//   vector_off_o      {0, id, 00}
//   in_service_o      interrupt being serviced
// Build option: define ZERORISCY_IRQ_EDGE_EN to add per-line edge detection
// with pending bits; otherwise every line is level-sensitive.
module zeroriscy_irq_ctrl
  import zeroriscy_defines::*;
#(
  parameter int unsigned N_IRQ  = 32,
  parameter int unsigned PRIO_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IRQ-1:0]        irq_i,
  input  logic [N_IRQ-1:0]        irq_mask_i,
  input  logic [N_IRQ*PRIO_W-1:0] irq_prio_i,
  input  logic [PRIO_W-1:0]       irq_thresh_i,
  input  logic                    irq_glb_en_i,
`ifdef ZERORISCY_IRQ_EDGE_EN
  input  logic [N_IRQ-1:0]        irq_edge_i,
`endif
  output logic                    irq_req_o,
  output logic [IRQ_ID_W-1:0]     irq_id_o,
  input  logic                    irq_ack_i,
  input  logic                    irq_eoi_i,
  output logic [5:0]              exc_cause_o,
  output logic [7:0]              vector_off_o,
  output logic                    in_service_o
);

  irq_state_t           state_q, state_d;
  logic [IRQ_ID_W-1:0]  id_q, id_d;
  logic                 req_q, req_d;
  logic                 svc_q, svc_d;
  logic                 ack_take;

  logic [N_IRQ-1:0]     src;
  logic [N_IRQ-1:0]     elig;
  logic [31:0]          elig_ext;
  logic                 arb_valid;
  logic [IRQ_ID_W-1:0]  arb_id;

`ifdef ZERORISCY_IRQ_EDGE_EN
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] irq_prev_q;
  logic [N_IRQ-1:0] pend_clr;

  // Set after clear so a new edge in the ack cycle survives.
  always_comb begin
    pend_clr = ack_take ? (N_IRQ'(1) << id_q) : '0;
    pend_d   = (pend_q & ~pend_clr) | (irq_i & ~irq_prev_q);
    src      = (irq_edge_i & pend_q) | (~irq_edge_i & irq_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      irq_prev_q <= '0;
    end else begin
      pend_q     <= pend_d;
      irq_prev_q <= irq_i;
    end
  end
`else
  always_comb src = irq_i;
`endif

  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      elig[k] = src[k] & irq_mask_i[k] & irq_glb_en_i &
                (irq_prio_i[k*PRIO_W +: PRIO_W] > irq_thresh_i);
    end
    // Zero-padded so id_q can index it for any N_IRQ.
    elig_ext           = '0;
    elig_ext[N_IRQ-1:0] = elig;
  end

  zeroriscy_irq_arbiter #(
    .N_IRQ  (N_IRQ),
    .PRIO_W (PRIO_W)
  ) u_arbiter (
    .elig  (elig),
    .prio  (irq_prio_i),
    .valid (arb_valid),
    .id    (arb_id)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    req_d    = req_q;
    svc_d    = svc_q;
    ack_take = 1'b0;
    unique case (state_q)
      IRQ_IDLE: begin
        if (arb_valid) begin
          state_d = IRQ_REQ;
          id_d    = arb_id;
          req_d   = 1'b1;
        end
      end
      IRQ_REQ: begin
        // Ack takes precedence over a simultaneous withdrawal.
        if (irq_ack_i) begin
          state_d  = IRQ_SERVICE;
          req_d    = 1'b0;
          svc_d    = 1'b1;
          ack_take = 1'b1;
        end else if (!elig_ext[id_q]) begin
          state_d = IRQ_IDLE;
          req_d   = 1'b0;
        end
      end
      IRQ_SERVICE: begin
        if (irq_eoi_i) begin
          state_d = IRQ_IDLE;
          svc_d   = 1'b0;
        end
      end
      default: begin
        state_d = IRQ_IDLE;
        req_d   = 1'b0;
        svc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IRQ_IDLE;
      id_q    <= '0;
      req_q   <= 1'b0;
      svc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      req_q   <= req_d;
      svc_q   <= svc_d;
    end
  end

  assign irq_req_o    = req_q;
  assign irq_id_o     = id_q;
  assign in_service_o = svc_q;
  assign exc_cause_o  = {IRQ_CAUSE_FLAG, id_q};
  assign vector_off_o = {1'b0, id_q, 2'b00};

endmodule

// File: tb/tb_zeroriscy_irq_ctrl.sv
module tb_zeroriscy_irq_ctrl;

  localparam int unsigned N_IRQ  = 32;
  localparam int unsigned PRIO_W = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic [N_IRQ-1:0]        irq;
  logic [N_IRQ-1:0]        irq_mask;
  logic [N_IRQ*PRIO_W-1:0] irq_prio;
  logic [PRIO_W-1:0]       irq_thresh;
  logic                    irq_glb_en;
`ifdef ZERORISCY_IRQ_EDGE_EN
  logic [N_IRQ-1:0]        irq_edge;
`endif
  logic                    irq_req;
  logic [4:0]              irq_id;
  logic                    irq_ack;
  logic                    irq_eoi;
  logic [5:0]              exc_cause;
  logic [7:0]              vector_off;
  logic                    in_service;

  int checks = 0;
  int passed = 0;

  zeroriscy_irq_ctrl #(
    .N_IRQ  (N_IRQ),
    .PRIO_W (PRIO_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_i        (irq),
    .irq_mask_i   (irq_mask),
    .irq_prio_i   (irq_prio),
    .irq_thresh_i (irq_thresh),
    .irq_glb_en_i (irq_glb_en),
`ifdef ZERORISCY_IRQ_EDGE_EN
    .irq_edge_i   (irq_edge),
`endif
    .irq_req_o    (irq_req),
    .irq_id_o     (irq_id),
    .irq_ack_i    (irq_ack),
    .irq_eoi_i    (irq_eoi),
    .exc_cause_o  (exc_cause),
    .vector_off_o (vector_off),
    .in_service_o (in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int k, input logic [PRIO_W-1:0] p);
    irq_prio[k*PRIO_W +: PRIO_W] = p;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   32'(irq_req),    32'h0);
    chk({tag, "_id"},    32'(irq_id),     32'h0);
    chk({tag, "_cause"}, 32'(exc_cause),  32'h20);
    chk({tag, "_vec"},   32'(vector_off), 32'h00);
    chk({tag, "_svc"},   32'(in_service), 32'h0);
  endtask

  initial begin
    irq = '0; irq_mask = '1; irq_prio = '0; irq_thresh = '0; irq_glb_en = 1'b1;
    irq_ack = 1'b0; irq_eoi = 1'b0;
`ifdef ZERORISCY_IRQ_EDGE_EN
    irq_edge = '0;
`endif
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    tick(); tick();
    rst_n = 1'b1;

    // Lines 3 and 7, equal priority -> lowest ID wins, one cycle latency
    set_prio(3, 2'd2); set_prio(7, 2'd2);
    irq[3] = 1'b1; irq[7] = 1'b1;
    #0 chk("lat_req_early", 32'(irq_req), 32'h0);
    tick();
    chk("tie_req",   32'(irq_req),    32'h1);
    chk("tie_id",    32'(irq_id),     32'd3);
    chk("tie_vec",   32'(vector_off), 32'h0c);
    chk("tie_cause", 32'(exc_cause),  32'h23);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("ack_req", 32'(irq_req),    32'h0);
    chk("ack_svc", 32'(in_service), 32'h1);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    chk("eoi_svc", 32'(in_service), 32'h0);
    chk("eoi_req", 32'(irq_req),    32'h0);
    tick();
    chk("reeoi_req", 32'(irq_req), 32'h1);
    chk("reeoi_id",  32'(irq_id),  32'd3);
    irq = '0; tick();
    chk("drop_req", 32'(irq_req), 32'h0);

    // Priority beats ID, then threshold suppresses
    set_prio(3, 2'd1); set_prio(7, 2'd3);
    irq[3] = 1'b1; irq[7] = 1'b1;
    tick();
    chk("prio_req", 32'(irq_req), 32'h1);
    chk("prio_id",  32'(irq_id),  32'd7);
    chk("prio_vec", 32'(vector_off), 32'h1c);
    irq_thresh = 2'd3; tick();
    chk("thr_wd_req", 32'(irq_req), 32'h0);
    tick();
    chk("thr_req", 32'(irq_req), 32'h0);
    irq = '0; irq_thresh = '0;

    // Withdrawal of level line 5
    set_prio(5, 2'd2); irq[5] = 1'b1; tick();
    chk("wd_req", 32'(irq_req), 32'h1);
    chk("wd_id",  32'(irq_id),  32'd5);
    irq[5] = 1'b0; tick();
    chk("wd_drop_req", 32'(irq_req), 32'h0);
    irq[5] = 1'b1; tick();
    chk("wd2_req", 32'(irq_req), 32'h1);
    irq[5] = 1'b0; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("ackwd_req", 32'(irq_req),    32'h0);
    chk("ackwd_svc", 32'(in_service), 32'h1);
    chk("ackwd_id",  32'(irq_id),     32'd5);

    // No nesting while in service
    set_prio(1, 2'd3); irq[1] = 1'b1; tick();
    chk("nest_req1", 32'(irq_req),    32'h0);
    chk("nest_svc1", 32'(in_service), 32'h1);
    tick();
    chk("nest_req2", 32'(irq_req), 32'h0);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    chk("nest_eoi_svc", 32'(in_service), 32'h0);
    chk("nest_eoi_req", 32'(irq_req),    32'h0);
    tick();
    chk("nest_post_req", 32'(irq_req), 32'h1);
    chk("nest_post_id",  32'(irq_id),  32'd1);
    chk("nest_post_cause", 32'(exc_cause), 32'h21);

    // Async reset while in REQ
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("areset");
    irq = '0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_req", 32'(irq_req), 32'h0);

`ifdef ZERORISCY_IRQ_EDGE_EN
    // Edge mode on line 9: pulse while masked, then unmask
    irq_edge[9] = 1'b1; set_prio(9, 2'd2); irq_mask[9] = 1'b0;
    irq[9] = 1'b1; tick();
    irq[9] = 1'b0; tick();
    chk("edge_masked_req", 32'(irq_req), 32'h0);
    irq_mask[9] = 1'b1; tick();
    chk("edge_req", 32'(irq_req), 32'h1);
    chk("edge_id",  32'(irq_id),  32'd9);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("edge_ack_svc", 32'(in_service), 32'h1);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    tick();
    chk("edge_clr_req", 32'(irq_req), 32'h0);
    // New edge coincident with ack
    irq[9] = 1'b1; tick();
    irq[9] = 1'b0; tick();
    chk("edge2_req", 32'(irq_req), 32'h1);
    irq[9] = 1'b1; irq_ack = 1'b1; tick(); irq_ack = 1'b0; irq[9] = 1'b0;
    chk("edge2_svc", 32'(in_service), 32'h1);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    chk("edge2_eoi_req", 32'(irq_req), 32'h0);
    tick();
    chk("edge2_rereq", 32'(irq_req), 32'h1);
    chk("edge2_id",    32'(irq_id),  32'd9);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
